// File: rtl/spi_sram_pkg.sv
// Shared constants and state encoding for the SPI SRAM Wishbone bridge.
package spi_sram_pkg;

   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_WRITE = 8'h02;

   localparam logic [2:0] CTI_CLASSIC           = 3'b000;
   localparam logic [2:0] CTI_INCREMENTAL_BURST = 3'b010;
   localparam logic [2:0] CTI_END_OF_BURST      = 3'b111;
   localparam logic [1:0] BTE_LINEAR_BURST      = 2'b00;

   localparam logic [1:0] CFG_NONE = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_DATA,
      ST_ACK,
      ST_HOLD,
      ST_GAP
   } state_e;

   // Active-low chip-select pattern for a config value; CFG_NONE selects nothing.
   function automatic logic [2:0] cs_decode(input logic [1:0] cfg);
      logic [2:0] cs_n;
      cs_n = 3'b111;
      if (cfg != CFG_NONE) cs_n[cfg] = 1'b0;
      return cs_n;
   endfunction

endpackage

// File: rtl/spi_sram_controller_shift.sv
// Mode-0 bit shifter: two clk cycles per bit, MSB first, data_i is MSB-aligned.
module spi_shift_engine (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [5:0]  len_i,
   input  logic [31:0] data_i,
   input  logic        miso_i,
   output logic        sck_o,
   output logic        mosi_o,
   output logic        done_o,
   output logic [7:0]  rx_next_o
);

   logic        busy_q, busy_d;
   logic        phase_q, phase_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] sh_q, sh_d;
   logic [7:0]  rx_q, rx_d;

   assign rx_next_o = {rx_q[6:0], miso_i};
   assign done_o    = busy_q & phase_q & (cnt_q == 5'd0);
   assign sck_o     = busy_q & phase_q;
   assign mosi_o    = busy_q & sh_q[31];

   always_comb begin
      busy_d  = busy_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      rx_d    = rx_q;
      if (busy_q) begin
         if (!phase_q) begin
            phase_d = 1'b1;
         end else begin
            // miso is captured on the edge that closes the sck-high phase
            phase_d = 1'b0;
            sh_d    = {sh_q[30:0], 1'b0};
            rx_d    = rx_next_o;
            if (cnt_q == 5'd0) busy_d = 1'b0;
            else               cnt_d  = cnt_q - 5'd1;
         end
      end
      if (start_i) begin
         busy_d  = 1'b1;
         phase_d = 1'b0;
         cnt_d   = 5'(len_i - 6'd1);
         sh_d    = data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         busy_q  <= 1'b0;
         phase_q <= 1'b0;
         cnt_q   <= '0;
         sh_q    <= '0;
         rx_q    <= '0;
      end else begin
         busy_q  <= busy_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         rx_q    <= rx_d;
      end
   end

endmodule

// File: rtl/spi_sram_controller.sv
// Wishbone B4 byte slave bridged to a 23LC1024-style SPI SRAM in sequential mode.
//  state | meaning
//  IDLE  | cs high, waiting for a request
//  CMD   | shifting opcode + 24-bit address
//  DATA  | shifting one data byte
//  ACK   | one-cycle ack/err
//  HOLD  | cs held low, waiting for the next sequential beat
//  GAP   | cs high for CS_HIGH_CYCLES before returning to IDLE
module spi_sram_controller
   import spi_sram_pkg::*;
#(
   parameter int ADDR_WIDTH     = 24,
   parameter int CS_HIGH_CYCLES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  wbs_cyc_i,
   input  logic                  wbs_stb_i,
   input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
   input  logic                  wbs_we_i,
   input  logic [7:0]            wbs_dat_i,
   input  logic [2:0]            wbs_cti_i,
   input  logic [1:0]            wbs_bte_i,
   output logic                  wbs_ack_o,
   output logic                  wbs_err_o,
   output logic                  wbs_rty_o,
   output logic [7:0]            wbs_dat_o,
   input  logic [1:0]            sram_config_i,
   output logic                  spi_sck_o,
   output logic                  spi_mosi_o,
   input  logic                  spi_miso_i,
   output logic [2:0]            spi_cs_n_o
);

   localparam int GW = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(CS_HIGH_CYCLES - 1);

   state_e        state_q, state_d;
   logic          we_q, we_d;
   logic [23:0]   adr_q, adr_d;
   logic [7:0]    wdat_q, wdat_d;
   logic [2:0]    cti_q, cti_d;
   logic [1:0]    bte_q, bte_d;
   logic [1:0]    cfg_q, cfg_d;
   logic          err_q, err_d;
   logic [7:0]    rdat_q, rdat_d;
   logic [GW-1:0] gap_q, gap_d;

   logic          req;
   logic [23:0]   adr24;
   logic          eng_start, eng_done;
   logic [5:0]    eng_len;
   logic [31:0]   eng_data;
   logic [7:0]    eng_rx_next;

   assign req   = wbs_cyc_i & wbs_stb_i;
   assign adr24 = 24'(wbs_adr_i);

   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      adr_d     = adr_q;
      wdat_d    = wdat_q;
      cti_d     = cti_q;
      bte_d     = bte_q;
      cfg_d     = cfg_q;
      err_d     = err_q;
      rdat_d    = rdat_q;
      gap_d     = gap_q;
      eng_start = 1'b0;
      eng_len   = 6'd32;
      eng_data  = '0;
      unique case (state_q)
         ST_IDLE: if (req) begin
            we_d   = wbs_we_i;
            adr_d  = adr24;
            wdat_d = wbs_dat_i;
            cti_d  = wbs_cti_i;
            bte_d  = wbs_bte_i;
            cfg_d  = sram_config_i;
            if (sram_config_i == CFG_NONE) begin
               err_d   = 1'b1;
               state_d = ST_ACK;
            end else begin
               err_d     = 1'b0;
               eng_start = 1'b1;
               eng_data  = {wbs_we_i ? OP_WRITE : OP_READ, adr24};
               state_d   = ST_CMD;
            end
         end
         ST_CMD: if (eng_done) begin
            eng_start = 1'b1;
            eng_len   = 6'd8;
            eng_data  = {we_q ? wdat_q : 8'h00, 24'h0};
            state_d   = ST_DATA;
         end
         ST_DATA: if (eng_done) begin
            if (!we_q) rdat_d = eng_rx_next;
            state_d = ST_ACK;
         end
         ST_ACK: begin
            if (!err_q && cti_q == CTI_INCREMENTAL_BURST && bte_q == BTE_LINEAR_BURST) begin
               state_d = ST_HOLD;
            end else begin
               gap_d   = GAP_LOAD;
               state_d = ST_GAP;
            end
         end
         ST_HOLD: begin
            if (req && wbs_we_i == we_q && adr24 == adr_q + 24'd1) begin
               adr_d     = adr24;
               wdat_d    = wbs_dat_i;
               cti_d     = wbs_cti_i;
               bte_d     = wbs_bte_i;
               eng_start = 1'b1;
               eng_len   = 6'd8;
               eng_data  = {wbs_we_i ? wbs_dat_i : 8'h00, 24'h0};
               state_d   = ST_DATA;
            end else if (req || !wbs_cyc_i) begin
               // the request that broke the burst is picked up again from IDLE
               gap_d   = GAP_LOAD;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_q == '0) state_d = ST_IDLE;
            else             gap_d   = gap_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         adr_q   <= '0;
         wdat_q  <= '0;
         cti_q   <= '0;
         bte_q   <= '0;
         cfg_q   <= CFG_NONE;
         err_q   <= 1'b0;
         rdat_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         cti_q   <= cti_d;
         bte_q   <= bte_d;
         cfg_q   <= cfg_d;
         err_q   <= err_d;
         rdat_q  <= rdat_d;
         gap_q   <= gap_d;
      end
   end

   spi_shift_engine u_shift (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .start_i   (eng_start),
      .len_i     (eng_len),
      .data_i    (eng_data),
      .miso_i    (spi_miso_i),
      .sck_o     (spi_sck_o),
      .mosi_o    (spi_mosi_o),
      .done_o    (eng_done),
      .rx_next_o (eng_rx_next)
   );

   assign wbs_ack_o  = (state_q == ST_ACK) & ~err_q;
   assign wbs_err_o  = (state_q == ST_ACK) & err_q;
   assign wbs_rty_o  = 1'b0;
   assign wbs_dat_o  = rdat_q;
   assign spi_cs_n_o = (state_q inside {ST_CMD, ST_DATA, ST_ACK, ST_HOLD}) ? cs_decode(cfg_q) : 3'b111;

endmodule

// File: tb/tb_spi_sram_controller.sv
// Directed bench for spi_sram_controller with a small SPI SRAM responder.
module tb_spi_sram_controller;
   import spi_sram_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        wbs_cyc_i = 1'b0;
   logic        wbs_stb_i = 1'b0;
   logic [23:0] wbs_adr_i = '0;
   logic        wbs_we_i = 1'b0;
   logic [7:0]  wbs_dat_i = '0;
   logic [2:0]  wbs_cti_i = '0;
   logic [1:0]  wbs_bte_i = '0;
   logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
   logic [7:0]  wbs_dat_o;
   logic [1:0]  sram_config_i = '0;
   logic        spi_sck_o, spi_mosi_o;
   logic        spi_miso_i = 1'b0;
   logic [2:0]  spi_cs_n_o;

   int checks = 0;
   int errors = 0;

   spi_sram_controller #(.ADDR_WIDTH(24), .CS_HIGH_CYCLES(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_adr_i(wbs_adr_i),
      .wbs_we_i(wbs_we_i), .wbs_dat_i(wbs_dat_i), .wbs_cti_i(wbs_cti_i),
      .wbs_bte_i(wbs_bte_i), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
      .wbs_rty_o(wbs_rty_o), .wbs_dat_o(wbs_dat_o), .sram_config_i(sram_config_i),
      .spi_sck_o(spi_sck_o), .spi_mosi_o(spi_mosi_o), .spi_miso_i(spi_miso_i),
      .spi_cs_n_o(spi_cs_n_o)
   );

   always #5 clk_i = ~clk_i;

   // SRAM side: records mosi at each sck rise, returns rd_bytes after the 32 command bits.
   logic [63:0] mosi_sr = '0;
   int          rises = 0;
   logic        sck_prev = 1'b0;
   logic [2:0]  cs_first = 3'b111;
   logic [7:0]  rd_bytes [2];

   always @(negedge clk_i) begin
      sck_prev <= spi_sck_o;
      if (&spi_cs_n_o) begin
         rises      <= 0;
         mosi_sr    <= '0;
         spi_miso_i <= 1'b0;
      end else if (spi_sck_o && !sck_prev) begin
         rises   <= rises + 1;
         mosi_sr <= {mosi_sr[62:0], spi_mosi_o};
         if (rises == 0) cs_first <= spi_cs_n_o;
         if (rises >= 32 && rises < 48)
            spi_miso_i <= rd_bytes[(rises - 32) / 8][7 - ((rises - 32) % 8)];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic we, input logic [23:0] adr, input logic [7:0] dat,
                        input logic [2:0] cti, input logic [1:0] cfg);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_adr_i = adr;
      wbs_dat_i = dat; wbs_cti_i = cti; wbs_bte_i = BTE_LINEAR_BURST; sram_config_i = cfg;
   endtask

   task automatic release_bus();
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
   endtask

   // n = edges until ack/err seen (the accepting edge is edge 1 when idle); cs_high counts idle-cs samples
   task automatic wait_resp(input int budget, output int n, output int cs_high);
      n = 0; cs_high = 0;
      do begin
         tick();
         n++;
         if (&spi_cs_n_o) cs_high++;
      end while (!(wbs_ack_o || wbs_err_o) && n < budget);
   endtask

   int n, csh;

   initial begin
      rd_bytes[0] = 8'h00; rd_bytes[1] = 8'h00;

      // reset
      tick(); tick();
      check("rst_ack", 64'(wbs_ack_o), 64'd0);
      check("rst_err", 64'(wbs_err_o), 64'd0);
      check("rst_dat", 64'(wbs_dat_o), 64'h00);
      check("rst_sck", 64'(spi_sck_o), 64'd0);
      check("rst_mosi", 64'(spi_mosi_o), 64'd0);
      check("rst_cs", 64'(spi_cs_n_o), 64'h7);
      check("rst_rty", 64'(wbs_rty_o), 64'd0);
      rst_ni = 1'b1;
      tick();

      // classic write, CS0
      drive(1'b1, 24'h001234, 8'hA5, CTI_CLASSIC, 2'd0);
      wait_resp(200, n, csh);
      check("wr_lat", 64'(n), 64'd81);
      check("wr_ack", 64'(wbs_ack_o), 64'd1);
      check("wr_rises", 64'(rises), 64'd40);
      check("wr_mosi", mosi_sr[39:0], 64'h02_001234_A5);
      check("wr_cs", 64'(cs_first), 64'h6);
      release_bus();
      tick();
      check("wr_ack_pulse", 64'(wbs_ack_o), 64'd0);
      check("wr_gap1", 64'(spi_cs_n_o), 64'h7);
      tick();
      check("wr_gap2", 64'(spi_cs_n_o), 64'h7);
      check("wr_dat_hold", 64'(wbs_dat_o), 64'h00);
      tick(); tick();

      // classic read, CS1
      rd_bytes[0] = 8'h3C;
      drive(1'b0, 24'h000200, 8'h00, CTI_CLASSIC, 2'd1);
      wait_resp(200, n, csh);
      check("rd_lat", 64'(n), 64'd81);
      check("rd_dat", 64'(wbs_dat_o), 64'h3C);
      check("rd_mosi", mosi_sr[39:0], {24'h0, 32'h03000200, 8'h00});
      check("rd_cs", 64'(cs_first), 64'h5);
      release_bus();
      tick(); tick(); tick(); tick();

      // incrementing read burst: one command, continuation 17 cycles after its accepting edge (+1 HOLD cycle)
      rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22;
      drive(1'b0, 24'h000402, 8'h00, CTI_INCREMENTAL_BURST, 2'd1);
      wait_resp(200, n, csh);
      check("br_lat1", 64'(n), 64'd81);
      check("br_dat1", 64'(wbs_dat_o), 64'h11);
      drive(1'b0, 24'h000403, 8'h00, CTI_END_OF_BURST, 2'd2);
      wait_resp(200, n, csh);
      check("br_lat2", 64'(n), 64'd18);
      check("br_cs_low", 64'(csh), 64'd0);
      check("br_dat2", 64'(wbs_dat_o), 64'h22);
      check("br_rises", 64'(rises), 64'd48);
      check("br_mosi", mosi_sr[47:0], {16'h0, 32'h03000402, 16'h0000});
      check("br_cs_sel", 64'(spi_cs_n_o), 64'h5);
      release_bus();
      tick();
      check("br_end_cs", 64'(spi_cs_n_o), 64'h7);
      tick(); tick(); tick();

      // burst broken by a non-sequential address: HOLD -> GAP(2) -> IDLE -> new command
      rd_bytes[0] = 8'h55;
      drive(1'b0, 24'h000500, 8'h00, CTI_INCREMENTAL_BURST, 2'd0);
      wait_resp(200, n, csh);
      check("ns_lat1", 64'(n), 64'd81);
      check("ns_dat1", 64'(wbs_dat_o), 64'h55);
      rd_bytes[0] = 8'h66;
      drive(1'b0, 24'h000010, 8'h00, CTI_CLASSIC, 2'd0);
      wait_resp(300, n, csh);
      check("ns_lat2", 64'(n), 64'd85);
      check("ns_cs_high", 64'(csh), 64'd3);
      check("ns_mosi", mosi_sr[39:0], {24'h0, 32'h03000010, 8'h00});
      check("ns_dat2", 64'(wbs_dat_o), 64'h66);
      release_bus();
      tick(); tick(); tick(); tick();

      // no device selected: err one cycle after accept, no SPI activity
      drive(1'b0, 24'h000020, 8'h00, CTI_CLASSIC, CFG_NONE);
      tick();
      check("nd_err", 64'(wbs_err_o), 64'd1);
      check("nd_ack", 64'(wbs_ack_o), 64'd0);
      check("nd_cs", 64'(spi_cs_n_o), 64'h7);
      check("nd_sck", 64'(spi_sck_o), 64'd0);
      release_bus();
      tick();
      check("nd_err_pulse", 64'(wbs_err_o), 64'd0);
      check("nd_dat_hold", 64'(wbs_dat_o), 64'h66);
      tick(); tick(); tick();

      // reset during command bit 10 aborts without ack
      drive(1'b0, 24'h000777, 8'h00, CTI_CLASSIC, 2'd2);
      for (int i = 0; i < 21; i++) tick();
      check("rs_bits", 64'(rises), 64'd10);
      check("rs_cs_mid", 64'(spi_cs_n_o), 64'h3);
      rst_ni = 1'b0;
      release_bus();
      tick();
      check("rs_cs", 64'(spi_cs_n_o), 64'h7);
      check("rs_sck", 64'(spi_sck_o), 64'd0);
      check("rs_ack", 64'(wbs_ack_o), 64'd0);
      check("rs_dat", 64'(wbs_dat_o), 64'h00);
      tick();
      rst_ni = 1'b1;
      tick();
      rd_bytes[0] = 8'h9A;
      drive(1'b0, 24'h000777, 8'h00, CTI_CLASSIC, 2'd2);
      wait_resp(200, n, csh);
      check("rs_lat", 64'(n), 64'd81);
      check("rs_rd_dat", 64'(wbs_dat_o), 64'h9A);
      release_bus();
      tick(); tick(); tick(); tick();

      // write burst across the 24-bit wrap counts as sequential
      drive(1'b1, 24'hFFFFFF, 8'h5A, CTI_INCREMENTAL_BURST, 2'd0);
      wait_resp(200, n, csh);
      check("wp_lat1", 64'(n), 64'd81);
      drive(1'b1, 24'h000000, 8'hC3, CTI_END_OF_BURST, 2'd0);
      wait_resp(200, n, csh);
      check("wp_lat2", 64'(n), 64'd18);
      check("wp_mosi", mosi_sr[47:0], {16'h0, 8'h02, 24'hFFFFFF, 8'h5A, 8'hC3});
      check("wp_dat_hold", 64'(wbs_dat_o), 64'h9A);
      release_bus();
      tick(); tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
